// File: rtl/main_memory_model_if.sv
// Miss-port bundle between the instruction cache (master) and the main-memory responder (slave).
interface main_memory_model_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128
);
  logic                  mem_ready;
  logic                  req_valid_miss;
  logic [ADDR_WIDTH-1:0] req_addr_miss;
  logic                  req_wr_miss;
  logic [LINE_WIDTH-1:0] req_wr_data_miss;
  logic                  rsp_valid_miss;
  logic [LINE_WIDTH-1:0] rsp_data_miss;

  modport master (
    input  mem_ready, rsp_valid_miss, rsp_data_miss,
    output req_valid_miss, req_addr_miss, req_wr_miss, req_wr_data_miss
  );

  modport slave (
    output mem_ready, rsp_valid_miss, rsp_data_miss,
    input  req_valid_miss, req_addr_miss, req_wr_miss, req_wr_data_miss
  );
endinterface

// File: rtl/main_memory_model.sv
// Fixed-latency main-memory responder for the icache miss port; one line request in flight.
// Define MAIN_MEMORY_WRITE_EN to enable line writes; otherwise every request is a read.
//
// state   | meaning
// IDLE    | mem_ready high, waiting for req_valid_miss
// BUSY    | latency countdown on captured request
// RESPOND | one-cycle rsp_valid_miss pulse; write committed here
module main_memory_model #(
  parameter int ADDR_WIDTH  = 32,
  parameter int LINE_WIDTH  = 128,
  parameter int DEPTH_LINES = 256,
  parameter int LATENCY     = 10
) (
  input  logic              clock,
  input  logic              reset,
  main_memory_model_if.slave bus
);
  localparam int OFF   = $clog2(LINE_WIDTH / 8);
  localparam int IDX_W = $clog2(DEPTH_LINES);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam int WORDS = LINE_WIDTH / 32;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, RESPOND} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0] idx_q;
  logic             wr_eff;
  logic [LINE_WIDTH-1:0] line_rd;
  logic             accept;

  assign accept = (state == IDLE) && bus.req_valid_miss;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx_q <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) idx_q <= bus.req_addr_miss[OFF +: IDX_W];
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (bus.req_valid_miss) begin
          cnt_nxt   = '0;
          state_nxt = (LATENCY == 1) ? RESPOND : BUSY;
        end
      end
      BUSY: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (cnt == CNT_TERM) state_nxt = RESPOND;
      end
      RESPOND: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef MAIN_MEMORY_WRITE_EN
  typedef logic [LINE_WIDTH-1:0] mem_t [DEPTH_LINES];

  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < DEPTH_LINES; i++) m[i] = {WORDS{32'(i)}};
    return m;
  endfunction

  // Array is deliberately outside reset so written lines survive it.
  mem_t                  mem = init_mem();
  logic                  wr_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic                  unused_inputs;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else if (accept) begin
      wr_q    <= bus.req_wr_miss;
      wdata_q <= bus.req_wr_data_miss;
    end
  end

  always_ff @(posedge clock) begin
    if (state == RESPOND && wr_q) mem[idx_q] <= wdata_q;
  end

  assign wr_eff        = wr_q;
  assign line_rd       = mem[idx_q];
  assign unused_inputs = ^bus.req_addr_miss;
`else
  logic unused_inputs;

  // Contents never change in this build, so the line is derived from its index.
  assign wr_eff        = 1'b0;
  assign line_rd       = {WORDS{32'(idx_q)}};
  assign unused_inputs = ^{bus.req_addr_miss, bus.req_wr_miss, bus.req_wr_data_miss};
`endif

  assign bus.mem_ready      = (state == IDLE);
  assign bus.rsp_valid_miss = (state == RESPOND);
  assign bus.rsp_data_miss  = (state == RESPOND && !wr_eff) ? line_rd : '0;
endmodule

// File: tb/tb_main_memory_model.sv
// Directed self-checking bench for main_memory_model (LATENCY=10 instance plus a LATENCY=1 instance).
module tb_main_memory_model;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   t_acc = 0;
  int   t1, t2, pulses;

  main_memory_model_if #(.ADDR_WIDTH(32), .LINE_WIDTH(128)) m ();
  main_memory_model_if #(.ADDR_WIDTH(32), .LINE_WIDTH(128)) m1 ();

  main_memory_model #(.ADDR_WIDTH(32), .LINE_WIDTH(128), .DEPTH_LINES(256), .LATENCY(10)) dut (
    .clock(clk), .reset(rst_n), .bus(m)
  );
  main_memory_model #(.ADDR_WIDTH(32), .LINE_WIDTH(128), .DEPTH_LINES(256), .LATENCY(1)) dut1 (
    .clock(clk), .reset(rst_n), .bus(m1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] rep(input logic [31:0] w);
    return {4{w}};
  endfunction

  // One request on the LATENCY=10 port; inputs are scrambled while busy to prove capture.
  task automatic do_req(input logic [31:0] addr, input logic wr, input logic [127:0] wdata,
                        input bit hold, input int exp_lat, input logic [127:0] exp_data,
                        input string tag);
    int lat;
    logic [127:0] got;
    lat = -1;
    got = '0;
    @(negedge clk);
    n_chk++;
    if (m.mem_ready !== 1'b1) begin
      n_fail++;
      $error("FAIL %s ready_before: observed %0h expected 1", tag, m.mem_ready);
    end
    m.req_valid_miss   = 1'b1;
    m.req_addr_miss    = addr;
    m.req_wr_miss      = wr;
    m.req_wr_data_miss = wdata;
    @(posedge clk);
    #1 t_acc = cyc;
    @(negedge clk);
    n_chk++;
    if (m.mem_ready !== 1'b0) begin
      n_fail++;
      $error("FAIL %s ready_busy: observed %0h expected 0", tag, m.mem_ready);
    end
    n_chk++;
    if (m.rsp_data_miss !== 128'h0) begin
      n_fail++;
      $error("FAIL %s data_idle: observed %0h expected 0", tag, m.rsp_data_miss);
    end
    m.req_addr_miss    = ~addr;
    m.req_wr_miss      = ~wr;
    m.req_wr_data_miss = ~wdata;
    for (int i = 1; i < 40; i++) begin
      if (m.rsp_valid_miss) begin
        lat = i;
        got = m.rsp_data_miss;
        break;
      end
      @(negedge clk);
    end
    n_chk++;
    if (lat !== exp_lat) begin
      n_fail++;
      $error("FAIL %s latency: observed %0d expected %0d", tag, lat, exp_lat);
    end
    n_chk++;
    if (got !== exp_data) begin
      n_fail++;
      $error("FAIL %s data: observed %0h expected %0h", tag, got, exp_data);
    end
    if (!hold) begin
      m.req_valid_miss = 1'b0;
      @(negedge clk);
      n_chk++;
      if (m.rsp_valid_miss !== 1'b0) begin
        n_fail++;
        $error("FAIL %s single_pulse: observed %0h expected 0", tag, m.rsp_valid_miss);
      end
      n_chk++;
      if (m.mem_ready !== 1'b1) begin
        n_fail++;
        $error("FAIL %s ready_after: observed %0h expected 1", tag, m.mem_ready);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] ack_exp, rd_exp;
    m.req_valid_miss = 1'b0;  m.req_addr_miss = '0;  m.req_wr_miss = 1'b0;  m.req_wr_data_miss = '0;
    m1.req_valid_miss = 1'b0; m1.req_addr_miss = '0; m1.req_wr_miss = 1'b0; m1.req_wr_data_miss = '0;

    #12;
    n_chk++;
    if (m.mem_ready !== 1'b1) begin
      n_fail++;
      $error("FAIL rst ready: observed %0h expected 1", m.mem_ready);
    end
    n_chk++;
    if (m.rsp_valid_miss !== 1'b0) begin
      n_fail++;
      $error("FAIL rst rsp_valid: observed %0h expected 0", m.rsp_valid_miss);
    end
    n_chk++;
    if (m.rsp_data_miss !== 128'h0) begin
      n_fail++;
      $error("FAIL rst rsp_data: observed %0h expected 0", m.rsp_data_miss);
    end
    n_chk++;
    if (m1.mem_ready !== 1'b1) begin
      n_fail++;
      $error("FAIL rst ready L1: observed %0h expected 1", m1.mem_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;

    do_req(32'h40, 1'b0, '0, 1'b0, 10, rep(32'h4), "rd_0x40");
    do_req(32'h4F, 1'b0, '0, 1'b0, 10, rep(32'h4), "rd_0x4F");
    do_req(32'h1040, 1'b0, '0, 1'b0, 10, rep(32'h4), "rd_0x1040");

    do_req(32'h100, 1'b0, '0, 1'b1, 10, rep(32'h10), "b2b_first");
    t1 = t_acc;
    do_req(32'h204, 1'b0, '0, 1'b0, 10, rep(32'h20), "b2b_second");
    t2 = t_acc;
    n_chk++;
    if (t2 - t1 !== 11) begin
      n_fail++;
      $error("FAIL b2b accept_gap: observed %0d expected 11", t2 - t1);
    end

`ifdef MAIN_MEMORY_WRITE_EN
    ack_exp = 128'h0;
    rd_exp  = rep(32'hDEADBEEF);
`else
    ack_exp = rep(32'h8);
    rd_exp  = rep(32'h8);
`endif
    do_req(32'h80, 1'b1, rep(32'hDEADBEEF), 1'b0, 10, ack_exp, "wr_0x80");
    do_req(32'h80, 1'b0, '0, 1'b0, 10, rd_exp, "rd_back_0x80");

    // Write to line 12 aborted by reset five cycles after acceptance.
    @(negedge clk);
    m.req_valid_miss = 1'b1; m.req_addr_miss = 32'hC0; m.req_wr_miss = 1'b1;
    m.req_wr_data_miss = rep(32'h55555555);
    @(posedge clk);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_chk++;
    if (m.mem_ready !== 1'b1) begin
      n_fail++;
      $error("FAIL abort ready: observed %0h expected 1", m.mem_ready);
    end
    n_chk++;
    if (m.rsp_valid_miss !== 1'b0) begin
      n_fail++;
      $error("FAIL abort rsp_valid: observed %0h expected 0", m.rsp_valid_miss);
    end
    n_chk++;
    if (m.rsp_data_miss !== 128'h0) begin
      n_fail++;
      $error("FAIL abort rsp_data: observed %0h expected 0", m.rsp_data_miss);
    end
    m.req_valid_miss = 1'b0;
    m.req_wr_miss = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (12) begin
      @(negedge clk);
      if (m.rsp_valid_miss) pulses++;
    end
    n_chk++;
    if (pulses !== 0) begin
      n_fail++;
      $error("FAIL abort no_pulse: observed %0d expected 0", pulses);
    end
    do_req(32'hC0, 1'b0, '0, 1'b0, 10, rep(32'hC), "rd_after_abort");

    // LATENCY=1: request held high across the response is re-accepted two edges later.
    @(negedge clk);
    m1.req_valid_miss = 1'b1; m1.req_addr_miss = 32'h30;
    @(posedge clk);
    @(negedge clk);
    n_chk++;
    if (m1.rsp_valid_miss !== 1'b1) begin
      n_fail++;
      $error("FAIL L1 rsp_valid: observed %0h expected 1", m1.rsp_valid_miss);
    end
    n_chk++;
    if (m1.rsp_data_miss !== rep(32'h3)) begin
      n_fail++;
      $error("FAIL L1 rsp_data: observed %0h expected %0h", m1.rsp_data_miss, rep(32'h3));
    end
    n_chk++;
    if (m1.mem_ready !== 1'b0) begin
      n_fail++;
      $error("FAIL L1 ready_resp: observed %0h expected 0", m1.mem_ready);
    end
    m1.req_addr_miss = 32'h40;
    @(negedge clk);
    n_chk++;
    if (m1.rsp_valid_miss !== 1'b0) begin
      n_fail++;
      $error("FAIL L1 idle rsp_valid: observed %0h expected 0", m1.rsp_valid_miss);
    end
    n_chk++;
    if (m1.mem_ready !== 1'b1) begin
      n_fail++;
      $error("FAIL L1 idle ready: observed %0h expected 1", m1.mem_ready);
    end
    @(negedge clk);
    n_chk++;
    if (m1.rsp_valid_miss !== 1'b1) begin
      n_fail++;
      $error("FAIL L1 second rsp_valid: observed %0h expected 1", m1.rsp_valid_miss);
    end
    n_chk++;
    if (m1.rsp_data_miss !== rep(32'h4)) begin
      n_fail++;
      $error("FAIL L1 second rsp_data: observed %0h expected %0h", m1.rsp_data_miss, rep(32'h4));
    end
    m1.req_valid_miss = 1'b0;
    @(negedge clk);
    n_chk++;
    if (m1.rsp_valid_miss !== 1'b0) begin
      n_fail++;
      $error("FAIL L1 end rsp_valid: observed %0h expected 0", m1.rsp_valid_miss);
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
